fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. It sits directly upstream of decode and the controller. It owns the PC, issues requests to the instruction memory over a valid/ready port, and buffers returning words in a 2-entry queue. It drives the IF/ID pipeline register (`InstrD`, `PCPlus8D`, `ValidD`). It obeys hazard-unit stalls and flushes, redirects on a taken branch (E) or a PC write (W), and holds fetch while `PCWrPendingF` is high.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to instruction
// memory, buffers up to two returned words and drives the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCWrPendingF,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        ImemReqValid,
  output logic [31:0] ImemAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);

  logic [31:0] pc_reg;
  logic [1:0]  out_cnt_reg, drop_cnt_reg, fifo_cnt_reg;
  logic [1:0]  out_cnt_next, drop_cnt_next, fifo_cnt_next;
  logic        fifo_rd_ptr_reg, fifo_wr_ptr_reg;
  logic        req_rd_ptr_reg, req_wr_ptr_reg;
  logic [31:0] instr_d_reg, pc8_d_reg;
  logic        valid_d_reg;

  logic [1:0][31:0] fifo_instr, fifo_pc8, req_pc;

  logic        redirect, accept, rsp_tracked, rsp_drop, rsp_live;
  logic        fifo_empty, load_en, load_head, load_rsp, fifo_push, fifo_pop;
  logic [31:0] redirect_pc, rsp_pc8;
  logic [2:0]  occupancy;

  assign redirect    = BranchTakenE | PCSrcW;
  assign redirect_pc = BranchTakenE ? ALUResultE : ResultW;

  // Issue depends only on registered occupancy, never on this cycle's redirect.
  assign occupancy    = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg};
  assign ImemReqValid = reset & ~StallF & ~PCWrPendingF & (occupancy < 3'd2);
  assign ImemAddr     = pc_reg;
  assign accept       = ImemReqValid & ImemReqReady;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_tracked = ImemRspValid & (out_cnt_reg != 2'd0);
  assign rsp_drop    = rsp_tracked & (drop_cnt_reg != 2'd0);
  assign rsp_live    = rsp_tracked & (drop_cnt_reg == 2'd0);
  assign rsp_pc8     = req_pc[req_rd_ptr_reg] + 32'd8;

  assign fifo_empty = (fifo_cnt_reg == 2'd0);
  assign load_en    = ~StallD & ~FlushD & ~redirect;
  assign load_head  = load_en & ~fifo_empty;
  assign load_rsp   = load_en & fifo_empty & rsp_live;
  assign fifo_pop   = load_head;
  assign fifo_push  = rsp_live & ~load_rsp & ~redirect;

  assign out_cnt_next  = out_cnt_reg + {1'b0, accept} - {1'b0, rsp_tracked};
  assign drop_cnt_next = redirect ? out_cnt_next : drop_cnt_reg - {1'b0, rsp_drop};
  assign fifo_cnt_next = redirect ? 2'd0
                       : fifo_cnt_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg          <= RESET_PC;
      out_cnt_reg     <= 2'd0;
      drop_cnt_reg    <= 2'd0;
      fifo_cnt_reg    <= 2'd0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_wr_ptr_reg <= 1'b0;
      req_rd_ptr_reg  <= 1'b0;
      req_wr_ptr_reg  <= 1'b0;
    end else begin
      if (redirect)    pc_reg <= redirect_pc;
      else if (accept) pc_reg <= pc_reg + 32'd4;
      out_cnt_reg  <= out_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if (accept)      req_wr_ptr_reg <= ~req_wr_ptr_reg;
      if (rsp_tracked) req_rd_ptr_reg <= ~req_rd_ptr_reg;
      if (redirect) begin
        fifo_rd_ptr_reg <= 1'b0;
        fifo_wr_ptr_reg <= 1'b0;
      end else begin
        if (fifo_push) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
        if (fifo_pop)  fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      end
    end
  end

  // Per-entry storage: return words and the request PC each word belongs to.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [31:0] instr_reg, pc8_reg, req_pc_reg;
    always_ff @(posedge clk) begin
      if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
        instr_reg <= ImemRspData;
        pc8_reg   <= rsp_pc8;
      end
      if (accept && (req_wr_ptr_reg == 1'(gi))) req_pc_reg <= pc_reg;
    end
    assign fifo_instr[gi] = instr_reg;
    assign fifo_pc8[gi]   = pc8_reg;
    assign req_pc[gi]     = req_pc_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_d_reg <= 1'b0;
      instr_d_reg <= BUBBLE;
      pc8_d_reg   <= 32'd0;
    end else if (!StallD) begin
      if (load_head) begin
        valid_d_reg <= 1'b1;
        instr_d_reg <= fifo_instr[fifo_rd_ptr_reg];
        pc8_d_reg   <= fifo_pc8[fifo_rd_ptr_reg];
      end else if (load_rsp) begin
        valid_d_reg <= 1'b1;
        instr_d_reg <= ImemRspData;
        pc8_d_reg   <= rsp_pc8;
      end else begin
        valid_d_reg <= 1'b0;
        instr_d_reg <= BUBBLE;
      end
    end
  end

  assign InstrD   = instr_d_reg;
  assign PCPlus8D = pc8_d_reg;
  assign ValidD   = valid_d_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model answers requests, a
// fetch-stream reference model predicts decode output, a monitor scores it.
module tb_fetch_stage;

  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
  localparam int K_NONE = 0, K_RESET = 1, K_HOLD = 2, K_BUBBLE = 3, K_VALID = 4;

  typedef struct { logic [31:0] instr; logic [31:0] pc8; } exp_t;
  typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCWrPendingF = 1'b0;
  logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic [31:0] ALUResultE = '0, ResultW = '0;
  logic        ImemReqValid, ImemReqReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(32'h0), .BUBBLE(BUBBLE)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
    .PCSrcW(PCSrcW), .ResultW(ResultW), .ImemReqValid(ImemReqValid), .ImemAddr(ImemAddr),
    .ImemReqReady(ImemReqReady), .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  int          p_ready = 100, lat_min = 1, lat_max = 1;

  // Reference model: next fetch address, words in flight, words returned but
  // not yet shown to decode, and an epoch bumped by every redirect or reset.
  logic [31:0] m_pc = 32'h0;
  int          m_inflight = 0, m_buf = 0;
  int unsigned m_epoch = 0;
  exp_t        exp_q[$];
  mem_t        mem_q[$];

  int          pend_kind = K_NONE;
  logic        last_valid = 1'b0;
  logic [31:0] last_instr = BUBBLE, last_pc8 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0: return r & 32'hFFFF_FFFC;
      1: return 32'hFFFF_FFF8;
      2: return r;
      default: return 32'($urandom_range(255)) << 2;
    endcase
  endfunction

  // One clock cycle: drive inputs, play memory, predict the coming edge.
  task automatic step(input logic rstn, input logic sf, input logic sd, input logic pw,
                      input logic bt, input logic [31:0] alu,
                      input logic ps, input logic [31:0] rw);
    logic        rsp, exp_valid, m_accept, redirect;
    int unsigned rsp_epoch;
    @(negedge clk);
    #1;
    cyc++;
    reset = rstn; StallF = sf; StallD = sd; PCWrPendingF = pw;
    BranchTakenE = bt; ALUResultE = alu; PCSrcW = ps; ResultW = rw;
    FlushD = bt | ps;
    ImemReqReady = ($urandom_range(99) < p_ready);
    rsp = 1'b0;
    rsp_epoch = 0;
    ImemRspValid = 1'b0;
    ImemRspData = $urandom;
    if (rstn && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp = 1'b1;
      rsp_epoch = mem_q[0].epoch;
      ImemRspValid = 1'b1;
      ImemRspData = mem_q[0].addr ^ KEY;
      void'(mem_q.pop_front());
    end
    #1;
    exp_valid = rstn & ~sf & ~pw & ((m_inflight + m_buf) < 2);
    chk("req_valid", ImemReqValid, exp_valid);
    if (exp_valid) chk("imem_addr", ImemAddr, m_pc);
    if (!rstn) begin
      mem_q.delete();
      exp_q.delete();
      m_pc = 32'h0; m_inflight = 0; m_buf = 0; m_epoch++;
      pend_kind = K_RESET;
      return;
    end
    if (ImemReqValid && ImemReqReady)
      mem_q.push_back('{ImemAddr, cyc + $urandom_range(lat_max, lat_min), m_epoch});
    checks++;
    if (mem_q.size() > 2) begin
      errors++;
      $display("FAIL outstanding actual=%0d required<=2 cycle=%0d", mem_q.size(), cyc);
    end
    m_accept = exp_valid & ImemReqReady;
    if (m_accept) begin
      exp_q.push_back('{m_pc ^ KEY, m_pc + 32'd8});
      m_pc = m_pc + 32'd4;
      m_inflight++;
    end
    if (rsp) begin
      m_inflight--;
      if (rsp_epoch == m_epoch) m_buf++;
    end
    redirect = bt | ps;
    if (redirect) begin
      m_pc = bt ? alu : rw;
      exp_q.delete();
      m_buf = 0;
      m_epoch++;
    end
    if (sd) pend_kind = K_HOLD;
    else if (redirect) pend_kind = K_BUBBLE;
    else if (m_buf > 0) begin
      m_buf--;
      pend_kind = K_VALID;
    end else pend_kind = K_BUBBLE;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: scores the IF/ID register after each edge against the model.
  initial begin
    exp_t item;
    forever begin
      @(negedge clk);
      case (pend_kind)
        K_RESET: begin
          chk("rst_valid", ValidD, 1'b0);
          chk("rst_instr", InstrD, BUBBLE);
          chk("rst_pc8", PCPlus8D, 32'h0);
          last_valid = 1'b0; last_instr = BUBBLE; last_pc8 = 32'h0;
        end
        K_HOLD: begin
          chk("hold_valid", ValidD, last_valid);
          chk("hold_instr", InstrD, last_instr);
          chk("hold_pc8", PCPlus8D, last_pc8);
        end
        K_BUBBLE: begin
          chk("bubble_valid", ValidD, 1'b0);
          chk("bubble_instr", InstrD, BUBBLE);
          chk("bubble_pc8", PCPlus8D, last_pc8);
          last_valid = 1'b0; last_instr = BUBBLE;
        end
        K_VALID: begin
          chk("load_valid", ValidD, 1'b1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual=%h required=none cycle=%0d", InstrD, cyc);
          end else begin
            item = exp_q.pop_front();
            chk("instr", InstrD, item.instr);
            chk("pc_plus8", PCPlus8D, item.pc8);
            $display("decode instr=%h pcplus8=%h cycle=%0d", InstrD, PCPlus8D, cyc);
            last_valid = 1'b1; last_instr = item.instr; last_pc8 = item.pc8;
          end
        end
        default: ;
      endcase
      pend_kind = K_NONE;
    end
  end

  initial begin
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (12) idle();
    // branch with two requests outstanding
    lat_min = 3; lat_max = 3;
    repeat (4) idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    lat_min = 1; lat_max = 1;
    repeat (8) idle();
    // simultaneous redirects: branch wins
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40);
    repeat (6) idle();
    // decode stall
    repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (6) idle();
    // memory backpressure then slow responses
    p_ready = 0;
    repeat (3) idle();
    p_ready = 100; lat_min = 3; lat_max = 3;
    repeat (10) idle();
    lat_min = 1; lat_max = 1;
    // pending PC write, then the write lands
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    repeat (6) idle();
    // address wrap-around
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    repeat (6) idle();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        p_ready = $urandom_range(100, 40);
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      step(1'b1, $urandom_range(99) < 15, $urandom_range(99) < 20, $urandom_range(99) < 6,
           $urandom_range(99) < 5, rand_target(), $urandom_range(99) < 4, rand_target());
    end
    // reset mid-stream
    p_ready = 100; lat_min = 2; lat_max = 2;
    repeat (3) idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    lat_min = 1; lat_max = 1;
    repeat (8) idle();
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
